// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// The checksum states exist only when UART_LOADER_CHECKSUM_EN is defined.
package uart_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_REQ,
        S_HDR_WAIT,
        S_DAT_REQ,
        S_DAT_WAIT,
        S_WRITE,
`ifdef UART_LOADER_CHECKSUM_EN
        S_CSUM_REQ,
        S_CSUM_WAIT,
`endif
        S_ACK_REQ,
        S_ACK_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] ACK_BYTE = 8'hAA;
    localparam logic [7:0] NAK_BYTE = 8'h55;
    localparam logic       RORS_RX  = 1'b1;
    localparam logic       RORS_TX  = 1'b0;

endpackage

// File: rtl/uart_byte_packer.sv
// Packs received bytes into a little-endian 32-bit word; word shows the
// assembled value including the byte arriving this cycle.
module uart_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx;
    logic [31:0] word_q;

    // Bypass the incoming byte so the full word is usable on the 4th byte's cycle.
    always_comb begin
        word = word_q;
        if (byte_vld)
            word[{idx, 3'b000} +: 8] = byte_in;
    end

    assign word_valid = byte_vld && (idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            word_q <= '0;
        end else if (clear) begin
            idx    <= '0;
            word_q <= '0;
        end else if (byte_vld) begin
            idx    <= idx + 2'd1;
            word_q <= word;
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// Boot loader: receives a length-prefixed image over uart_unit, writes words to
// instruction memory and answers ACK/NAK. Optional checksum: UART_LOADER_CHECKSUM_EN.
module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              uart_go,
    output logic              rors,
    output logic [7:0]        txdata,
    input  logic [7:0]        rxdata,
    input  logic              uart_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [32:0]   CAP     = 33'd1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_t        PAY_END = S_CSUM_REQ;
`else
    localparam state_t        PAY_END = S_ACK_REQ;
`endif

    state_t            state, nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   nwords;
    logic              nak;
    logic              rx_vld;
    logic [31:0]       word;
    logic              word_valid;
    logic              hdr_big;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign rx_vld  = uart_done && (state == S_HDR_WAIT || state == S_DAT_WAIT);
    assign hdr_big = {1'b0, word} > CAP;

    uart_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == S_IDLE),
        .byte_vld   (rx_vld),
        .byte_in    (rxdata),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt       = state;
        uart_go   = 1'b0;
        rors      = 1'b0;
        txdata    = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state != S_IDLE);
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state)
            S_IDLE:     if (start) nxt = S_HDR_REQ;
            S_HDR_REQ: begin
                uart_go = 1'b1;
                rors    = RORS_RX;
                nxt     = S_HDR_WAIT;
            end
            S_HDR_WAIT: begin
                if (word_valid) begin
                    if (word == '0)   nxt = PAY_END;
                    else if (hdr_big) nxt = S_ACK_REQ;
                    else              nxt = S_DAT_REQ;
                end else if (uart_done) begin
                    nxt = S_HDR_REQ;
                end
            end
            S_DAT_REQ: begin
                uart_go = 1'b1;
                rors    = RORS_RX;
                nxt     = S_DAT_WAIT;
            end
            S_DAT_WAIT: begin
                if (word_valid)     nxt = S_WRITE;
                else if (uart_done) nxt = S_DAT_REQ;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = BASE_ADDR + cnt[ADDR_W-1:0];
                mem_wdata = word;
                nxt       = (cnt + ONE == nwords) ? PAY_END : S_DAT_REQ;
            end
`ifdef UART_LOADER_CHECKSUM_EN
            S_CSUM_REQ: begin
                uart_go = 1'b1;
                rors    = RORS_RX;
                nxt     = S_CSUM_WAIT;
            end
            S_CSUM_WAIT: if (uart_done) nxt = S_ACK_REQ;
`endif
            S_ACK_REQ: begin
                uart_go = 1'b1;
                rors    = RORS_TX;
                txdata  = nak ? NAK_BYTE : ACK_BYTE;
                nxt     = S_ACK_WAIT;
            end
            S_ACK_WAIT: begin
                txdata = nak ? NAK_BYTE : ACK_BYTE;
                if (uart_done) nxt = S_DONE;
            end
            S_DONE: begin
                load_done = 1'b1;
                load_err  = nak;
                nxt       = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Per-load bookkeeping; only the accepted start clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            nwords <= '0;
            nak    <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cnt  <= '0;
                    nak  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum <= '0;
`endif
                end
                S_HDR_WAIT: if (word_valid) begin
                    nwords <= word[ADDR_W:0];
                    if (hdr_big) nak <= 1'b1;
                end
`ifdef UART_LOADER_CHECKSUM_EN
                S_DAT_WAIT:  if (uart_done) csum <= csum ^ rxdata;
                S_CSUM_WAIT: if (uart_done && rxdata != csum) nak <= 1'b1;
`endif
                S_WRITE: cnt <= cnt + ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Randomized bench for uart_word_loader with a behavioural uart_unit responder
// and a load-level reference model.
module tb_uart_word_loader;

    localparam int                ADDR_W = 4;
    localparam int                CAP    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE   = '0;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit                CSUM_EN = 1'b1;
`else
    localparam bit                CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0, rst = 1'b1, start = 1'b0, uart_done = 1'b0;
    logic [7:0]        rxdata = '0;
    logic              uart_go, rors, mem_we, busy, load_done, load_err;
    logic [7:0]        txdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    uart_word_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .uart_go(uart_go), .rors(rors),
        .txdata(txdata), .rxdata(rxdata), .uart_done(uart_done), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct packed {
        logic        to;
        logic [7:0]  dones;
        logic        errl;
        logic [7:0]  ntx;
        logic [7:0]  tx0;
        logic [15:0] gos;
        logic [7:0]  ovl;
        logic [7:0]  unst;
        logic        bdone;
        logic        bafter;
        logic [7:0]  left;
    } sum_t;

    wr_t        act_wr[$], exp_wr[$];
    logic [7:0] rx_q[$], act_tx[$];
    sum_t       act_sum, exp_sum;
    int         go_cnt, rx_cnt, done_cnt, ovl, unst, n_cmp, n_err;
    int         min_dly = 0, max_dly = 3;
    logic       err_last;
    bit         spurious;

    // uart_unit stand-in: one request at a time, random latency, random rxdata off-cycle.
    initial begin
        bit         pending = 0, pend_rx = 0, was_pending;
        int         wait_cnt = 0;
        logic [7:0] tx_hold = '0;
        forever begin
            @(negedge clk);
            uart_done = 1'b0;
            rxdata    = 8'($urandom);
            if (rst) begin
                pending  = 0;
                spurious = 0;
            end else begin
                was_pending = pending;
                if (spurious) begin
                    uart_done = 1'b1;
                    spurious  = 0;
                end
                if (pending) begin
                    if (!pend_rx && txdata !== tx_hold) unst++;
                    if (wait_cnt == 0) begin
                        uart_done = 1'b1;
                        pending   = 0;
                        if (pend_rx) begin
                            rxdata = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
                            rx_cnt++;
                        end else begin
                            act_tx.push_back(tx_hold);
                        end
                    end else begin
                        wait_cnt--;
                    end
                end
                if (uart_go) begin
                    go_cnt++;
                    if (was_pending) ovl++;
                    pending  = 1;
                    pend_rx  = rors;
                    tx_hold  = txdata;
                    wait_cnt = $urandom_range(max_dly, min_dly);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (mem_we) act_wr.push_back('{addr: mem_addr, data: mem_wdata});
        if (load_done) begin
            done_cnt++;
            err_last = load_err;
        end
    end

    task automatic launch(input logic [31:0] n, input logic [31:0] w[$], input bit bad);
        logic [7:0] x = '0;
        @(negedge clk); #1;
        rx_q.delete(); act_wr.delete(); act_tx.delete();
        go_cnt = 0; rx_cnt = 0; done_cnt = 0; ovl = 0; unst = 0; err_last = 1'bx;
        for (int b = 0; b < 4; b++) rx_q.push_back(n[8*b +: 8]);
        if (n <= CAP) begin
            for (int i = 0; i < int'(n); i++)
                for (int b = 0; b < 4; b++) begin
                    rx_q.push_back(w[i][8*b +: 8]);
                    x ^= w[i][8*b +: 8];
                end
            if (CSUM_EN) rx_q.push_back(x ^ {7'd0, bad});
        end
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_load(input int extra_at);
        bit fired = 0;
        for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (!fired && extra_at >= 0 && rx_cnt == extra_at) begin
                start = 1'b1;
                fired = 1;
            end
        end
        act_sum.to    = (done_cnt == 0);
        act_sum.bdone = busy;
        @(negedge clk); #1;
        start = 1'b0;
        act_sum.bafter = busy;
        repeat (4) @(negedge clk);
        #1;
        act_sum.dones = 8'(done_cnt);
        act_sum.errl  = err_last;
        act_sum.ntx   = 8'(act_tx.size());
        act_sum.tx0   = (act_tx.size() > 0) ? act_tx[0] : 8'hxx;
        act_sum.gos   = 16'(go_cnt);
        act_sum.ovl   = 8'(ovl);
        act_sum.unst  = 8'(unst);
        act_sum.left  = 8'(rx_q.size());
        if (act_sum.to) begin
            rst = 1'b1;
            @(negedge clk); #1;
            rst = 1'b0;
        end
    endtask

    // Load-level expectation: which words land where, which reply byte, how many requests.
    task automatic model_load(input logic [31:0] n, input logic [31:0] w[$], input bit bad);
        bit ok  = (n <= CAP);
        bit nak = !ok || (CSUM_EN && bad);
        int nrx = 4 + (ok ? 4 * int'(n) + int'(CSUM_EN) : 0);
        exp_wr.delete();
        if (ok)
            for (int i = 0; i < int'(n); i++)
                exp_wr.push_back('{addr: ADDR_W'(int'(BASE) + i), data: w[i]});
        exp_sum = '{to: 1'b0, dones: 8'd1, errl: nak, ntx: 8'd1,
                    tx0: nak ? 8'h55 : 8'hAA, gos: 16'(nrx + 1), ovl: 8'd0,
                    unst: 8'd0, bdone: 1'b1, bafter: 1'b0, left: 8'd0};
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({uart_go, rors, txdata, mem_we, mem_addr, mem_wdata, busy, load_done, load_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {uart_go, rors, txdata, mem_we, mem_addr, mem_wdata, busy, load_done, load_err});
        end
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        go_cnt = 0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, 8'(go_cnt)} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_start_ignored: busy=%b go=%0d want 0/0", busy, go_cnt);
        end
    endtask

    task automatic test_basic();
        logic [31:0] w[$] = {32'h11223344, 32'hDEADBEEF};
        launch(2, w, 0); finish_load(-1); model_load(2, w, 0);
        n_cmp++;
        if (act_sum !== exp_sum) begin n_err++; $display("FAIL basic_sum: got %h want %h", act_sum, exp_sum); end
        n_cmp++;
        if (act_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL basic_nwr: got %0d want %0d", act_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[k]) begin
            n_cmp++;
            if (act_wr[k] !== exp_wr[k]) begin n_err++; $display("FAIL basic_wr%0d: got %h want %h", k, act_wr[k], exp_wr[k]); end
        end
    endtask

    task automatic test_zero();
        logic [31:0] w[$] = {};
        launch(0, w, 0); finish_load(-1); model_load(0, w, 0);
        n_cmp++;
        if (act_sum !== exp_sum) begin n_err++; $display("FAIL zero_sum: got %h want %h", act_sum, exp_sum); end
        n_cmp++;
        if (act_wr.size() != 0) begin n_err++; $display("FAIL zero_nwr: got %0d want 0", act_wr.size()); end
    endtask

    task automatic test_capacity();
        logic [31:0] lens[3] = '{32'd17, 32'd16, 32'h0010_0010};
        foreach (lens[t]) begin
            logic [31:0] w[$];
            for (int i = 0; i < CAP + 1; i++) w.push_back($urandom);
            launch(lens[t], w, 0); finish_load(-1); model_load(lens[t], w, 0);
            n_cmp++;
            if (act_sum !== exp_sum) begin n_err++; $display("FAIL cap%0d_sum: got %h want %h", t, act_sum, exp_sum); end
            n_cmp++;
            if (act_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL cap%0d_nwr: got %0d want %0d", t, act_wr.size(), exp_wr.size()); end
            else foreach (exp_wr[k]) begin
                n_cmp++;
                if (act_wr[k] !== exp_wr[k]) begin n_err++; $display("FAIL cap%0d_wr%0d: got %h want %h", t, k, act_wr[k], exp_wr[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w1[$] = {32'h11223344, 32'h55667788};
        logic [31:0] w2[$] = {32'hCAFEF00D, 32'h0BADBEEF};
        int go_snap;
        launch(2, w1, 0);
        for (int c = 0; c < 500 && rx_cnt < 6; c++) begin @(negedge clk); #1; end
        n_cmp++;
        if (rx_cnt != 6) begin n_err++; $display("FAIL rmid_progress: got %0d bytes want 6", rx_cnt); end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({uart_go, rors, txdata, mem_we, mem_addr, mem_wdata, busy, load_done, load_err} !== '0) begin
            n_err++;
            $display("FAIL rmid_outputs: got %h want 0",
                     {uart_go, rors, txdata, mem_we, mem_addr, mem_wdata, busy, load_done, load_err});
        end
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        go_snap = go_cnt;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if ({8'(act_wr.size()), 8'(go_cnt - go_snap), busy} !== 17'd0) begin
            n_err++;
            $display("FAIL rmid_quiet: wr=%0d go=%0d busy=%b want 0/0/0", act_wr.size(), go_cnt - go_snap, busy);
        end
        launch(2, w2, 0); finish_load(-1); model_load(2, w2, 0);
        n_cmp++;
        if (act_sum !== exp_sum) begin n_err++; $display("FAIL rmid_sum: got %h want %h", act_sum, exp_sum); end
        n_cmp++;
        if (act_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL rmid_nwr: got %0d want %0d", act_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[k]) begin
            n_cmp++;
            if (act_wr[k] !== exp_wr[k]) begin n_err++; $display("FAIL rmid_wr%0d: got %h want %h", k, act_wr[k], exp_wr[k]); end
        end
    endtask

    task automatic test_ignore();
        logic [31:0] w[$] = {32'h0A0B0C0D, 32'h01020304};
        logic [31:0] w1[$] = {32'h89ABCDEF};
        @(negedge clk); #1;
        go_cnt = 0;
        repeat (3) begin
            spurious = 1;
            @(negedge clk); #1;
            @(negedge clk); #1;
        end
        n_cmp++;
        if ({8'(go_cnt), busy} !== 9'd0) begin n_err++; $display("FAIL idle_done: go=%0d busy=%b want 0/0", go_cnt, busy); end
        launch(2, w, 0); finish_load(5); model_load(2, w, 0);
        n_cmp++;
        if (act_sum !== exp_sum) begin n_err++; $display("FAIL midstart_sum: got %h want %h", act_sum, exp_sum); end
        n_cmp++;
        if (act_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL midstart_nwr: got %0d want %0d", act_wr.size(), exp_wr.size()); end
        else foreach (exp_wr[k]) begin
            n_cmp++;
            if (act_wr[k] !== exp_wr[k]) begin n_err++; $display("FAIL midstart_wr%0d: got %h want %h", k, act_wr[k], exp_wr[k]); end
        end
        min_dly = 100; max_dly = 100;
        launch(1, w1, 0); finish_load(-1); model_load(1, w1, 0);
        min_dly = 0; max_dly = 3;
        n_cmp++;
        if (act_sum !== exp_sum) begin n_err++; $display("FAIL slow_sum: got %h want %h", act_sum, exp_sum); end
        n_cmp++;
        if (act_wr.size() != 1 || act_wr[0] !== exp_wr[0]) begin n_err++; $display("FAIL slow_wr: got %0d writes want 1 of %h", act_wr.size(), exp_wr[0]); end
    endtask

    task automatic test_checksum();
        logic [31:0] w[$] = {32'h04030201};
        for (int bad = 0; bad < 2; bad++) begin
            launch(1, w, bad[0]); finish_load(-1); model_load(1, w, bad[0]);
            n_cmp++;
            if (act_sum !== exp_sum) begin n_err++; $display("FAIL csum%0d_sum: got %h want %h", bad, act_sum, exp_sum); end
            n_cmp++;
            if (act_wr.size() != 1 || act_wr[0] !== exp_wr[0]) begin n_err++; $display("FAIL csum%0d_wr: got %0d writes want 1 of %h", bad, act_wr.size(), exp_wr[0]); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [31:0] n;
            logic [31:0] w[$];
            bit          bad;
            n = (t == 3) ? 32'h0010_0010 : 32'($urandom_range(CAP + 2, 0));
            for (int i = 0; i < CAP + 2; i++) w.push_back($urandom);
            bad     = 1'($urandom_range(1, 0));
            max_dly = $urandom_range(6, 0);
            launch(n, w, bad); finish_load(-1); model_load(n, w, bad);
            n_cmp++;
            if (act_sum !== exp_sum) begin n_err++; $display("FAIL rnd%0d_sum: n=%0d got %h want %h", t, n, act_sum, exp_sum); end
            n_cmp++;
            if (act_wr.size() != exp_wr.size()) begin n_err++; $display("FAIL rnd%0d_nwr: got %0d want %0d", t, act_wr.size(), exp_wr.size()); end
            else foreach (exp_wr[k]) begin
                n_cmp++;
                if (act_wr[k] !== exp_wr[k]) begin n_err++; $display("FAIL rnd%0d_wr%0d: got %h want %h", t, k, act_wr[k], exp_wr[k]); end
            end
        end
        max_dly = 3;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_zero();
        test_capacity();
        test_reset_mid();
        test_ignore();
        test_checksum();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
